i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx_if.sv | 26 ++
 rtl/i2s_tx.sv | 122 ++++++++++++
 tb/tb_i2s_tx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: sample-pair handshake between a sample producer and i2s_tx.
//   din_left  [15:0]  left sample, two's complement
//   din_right [15:0]  right sample, two's complement
//   din_valid         producer offers a pair
//   din_ready         transmitter holding register is empty
// A pair transfers on a sysclk edge where din_valid and din_ready are both high.
interface i2s_tx_if;
  logic [15:0] din_left;
  logic [15:0] din_right;
  logic        din_valid;
  logic        din_ready;

  modport master (
    output din_left,
    output din_right,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din_left,
    input  din_right,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter, 16-bit stereo, 32 bit-clocks per frame.
//   sysclk    system clock, everything on its rising edge
//   rst       synchronous active-low reset
//   din       i2s_tx_if.slave sample-pair handshake (one-deep holding register)
//   bclk      bit clock, half-period BCLK_DIV sysclk cycles
//   wclk      word clock, 0 = left word, 1 = right word
//   dout      serial data, MSB first, one bclk after the wclk change
//   underrun  one-cycle pulse when a frame starts with no pair held
module i2s_tx #(
  parameter int BCLK_DIV = 4
) (
  input  logic      sysclk,
  input  logic      rst,
  i2s_tx_if.slave   din,
  output logic      bclk,
  output logic      wclk,
  output logic      dout,
  output logic      underrun
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0]  div_r;
  logic [4:0]  slot_r;
  logic [15:0] left_r;
  logic [15:0] right_r;
  logic [15:0] hold_left_r;
  logic [15:0] hold_right_r;
  logic        full_r;
  logic        ready_r;

  logic        tc_s;
  logic        rise_s;
  logic        load_s;
  logic        xfer_s;
  logic [4:0]  slot_next_s;
  logic [3:0]  bidx_s;
  logic        dout_next_s;

  assign din.din_ready = ready_r;

  // Edge decode and next serial bit for the slot being entered.
  // Both 16-slot and 32-slot offsets reduce to the same 4-bit index:
  // (16 - slot) mod 16 == (32 - slot) mod 16 == -slot mod 16.
  always_comb begin
    tc_s        = (div_r == DIV_LAST);
    rise_s      = tc_s && !bclk;
    slot_next_s = slot_r + 5'd1;
    load_s      = rise_s && (slot_next_s == 5'd1);
    xfer_s      = din.din_valid && ready_r;
    bidx_s      = 4'd0 - slot_next_s[3:0];
    dout_next_s = 1'b0;
    if (slot_next_s == 5'd1) begin
      dout_next_s = full_r ? hold_left_r[15] : 1'b0;
    end else if ((slot_next_s == 5'd0) || (slot_next_s >= 5'd17)) begin
      dout_next_s = right_r[bidx_s];
    end else begin
      dout_next_s = left_r[bidx_s];
    end
  end

  // Divider, slot sequencing, serial outputs and holding register.
  always_ff @(posedge sysclk) begin
    if (!rst) begin
      div_r        <= 8'd0;
      slot_r       <= 5'd0;
      bclk         <= 1'b0;
      wclk         <= 1'b0;
      dout         <= 1'b0;
      underrun     <= 1'b0;
      left_r       <= 16'h0000;
      right_r      <= 16'h0000;
      hold_left_r  <= 16'h0000;
      hold_right_r <= 16'h0000;
      full_r       <= 1'b0;
      ready_r      <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (tc_s) begin
        div_r <= 8'd0;
        bclk  <= ~bclk;
      end else begin
        div_r <= div_r + 8'd1;
      end

      // bclk rising: move to the next slot and present its bit.
      if (rise_s) begin
        slot_r <= slot_next_s;
        dout   <= dout_next_s;
        if (slot_next_s == 5'd0) begin
          wclk <= 1'b0;
        end else if (slot_next_s == 5'd16) begin
          wclk <= 1'b1;
        end
        if (load_s) begin
          if (full_r) begin
            left_r  <= hold_left_r;
            right_r <= hold_right_r;
            full_r  <= 1'b0;
          end else begin
            left_r   <= 16'h0000;
            right_r  <= 16'h0000;
            underrun <= 1'b1;
          end
        end
      end

      // A transfer can only happen while the register is empty, so it
      // never competes with a load of held contents.
      if (xfer_s) begin
        hold_left_r  <= din.din_left;
        hold_right_r <= din.din_right;
        full_r       <= 1'b1;
      end

      // Ready drops on the transfer edge and returns one edge after the
      // holding register empties.
      ready_r <= xfer_s ? 1'b0 : ~full_r;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: one instance at BCLK_DIV=4, one at BCLK_DIV=2.
// Outputs are recorded at every falling sysclk edge into a history indexed
// by the number of rising edges since reset release; expectations are
// hand-derived from the frame timing (slot s of frame k is entered on edge
// 256*(k-1)+8*s-4 at BCLK_DIV=4, and sampled at the bclk fall 4 edges later).
module tb_i2s_tx;
  logic sysclk = 1'b0;
  logic rst    = 1'b0;
  always #5 sysclk = ~sysclk;

  i2s_tx_if bus_a ();
  i2s_tx_if bus_b ();
  logic bclk_a, wclk_a, dout_a, underrun_a;
  logic bclk_b, wclk_b, dout_b, underrun_b;

  i2s_tx #(.BCLK_DIV(4)) dut_a (
    .sysclk(sysclk), .rst(rst), .din(bus_a),
    .bclk(bclk_a), .wclk(wclk_a), .dout(dout_a), .underrun(underrun_a)
  );

  i2s_tx #(.BCLK_DIV(2)) dut_b (
    .sysclk(sysclk), .rst(rst), .din(bus_b),
    .bclk(bclk_b), .wclk(wclk_b), .dout(dout_b), .underrun(underrun_b)
  );

  localparam int HLEN = 1200;
  localparam int BA = 0, WA = 1, DA = 2, UA = 3, RA = 4;
  localparam int BB = 5, WB = 6, DB = 7, UB = 8, RB = 9;

  logic [9:0] hist [0:HLEN-1];
  int checks   = 0;
  int failures = 0;
  int e        = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge sysclk);
    e++;
    if (e < HLEN) begin
      hist[e] = {bus_b.din_ready, underrun_b, dout_b, wclk_b, bclk_b,
                 bus_a.din_ready, underrun_a, dout_a, wclk_a, bclk_a};
    end
  endtask

  task automatic run_to(input int t);
    while (e < t) step();
  endtask

  task automatic grab(input int base, input int first, input int stride,
                      input int bitpos, output logic [15:0] w);
    w = 16'h0000;
    for (int s = first; s < first + 16; s++) begin
      w = {w[14:0], hist[base + stride * s][bitpos]};
    end
  endtask

  function automatic logic [31:0] hb(input int idx, input int bitpos);
    logic [9:0] v;
    v = hist[idx];
    return {31'd0, v[bitpos]};
  endfunction

  logic [15:0] word_s;
  int          cnt_s;

  initial begin
    bus_a.din_valid = 1'b0; bus_a.din_left = 16'h0000; bus_a.din_right = 16'h0000;
    bus_b.din_valid = 1'b0; bus_b.din_left = 16'h0000; bus_b.din_right = 16'h0000;
    for (int i = 0; i < HLEN; i++) hist[i] = 10'd0;

    // Reset state.
    repeat (3) @(negedge sysclk);
    chk("rst_bclk",     {31'd0, bclk_a},          32'd0);
    chk("rst_wclk",     {31'd0, wclk_a},          32'd0);
    chk("rst_dout",     {31'd0, dout_a},          32'd0);
    chk("rst_underrun", {31'd0, underrun_a},      32'd0);
    chk("rst_ready",    {31'd0, bus_a.din_ready}, 32'd0);
    rst = 1'b1;
    e   = 0;

    // Offer A55A/0F0F to A, and 8000/0001 to B for its second frame.
    step();
    bus_a.din_valid = 1'b1; bus_a.din_left = 16'hA55A; bus_a.din_right = 16'h0F0F;
    step();
    bus_a.din_valid = 1'b0; bus_a.din_left = 16'hFFFF; bus_a.din_right = 16'hFFFF;
    step();
    bus_b.din_valid = 1'b1; bus_b.din_left = 16'h8000; bus_b.din_right = 16'h0001;
    step();
    bus_b.din_valid = 1'b0;
    run_to(264);

    // A: pair held continuously across frames 2 and 3, changed mid-frame.
    bus_a.din_valid = 1'b1; bus_a.din_left = 16'h1234; bus_a.din_right = 16'h8001;
    run_to(266);
    bus_a.din_left = 16'h7FFF; bus_a.din_right = 16'hFFFF;
    run_to(518);
    bus_a.din_valid = 1'b0;
    run_to(773);
    bus_a.din_valid = 1'b1; bus_a.din_left = 16'hDEAD; bus_a.din_right = 16'hBEEF;
    step();
    bus_a.din_valid = 1'b0;

    // Reset during slot 20 of frame 4 with DEAD/BEEF held.
    run_to(928);
    rst = 1'b0;
    step();
    chk("mid_rst_bclk",     {31'd0, bclk_a},          32'd0);
    chk("mid_rst_wclk",     {31'd0, wclk_a},          32'd0);
    chk("mid_rst_dout",     {31'd0, dout_a},          32'd0);
    chk("mid_rst_underrun", {31'd0, underrun_a},      32'd0);
    chk("mid_rst_ready",    {31'd0, bus_a.din_ready}, 32'd0);
    rst = 1'b1;
    run_to(929 + 264);

    // Handshake timing, A.
    chk("ready_after_rel", hb(1, RA),   32'd1);
    chk("ready_xfer",      hb(2, RA),   32'd0);
    chk("ready_load",      hb(4, RA),   32'd0);
    chk("ready_reopen",    hb(5, RA),   32'd1);
    chk("ready_xfer2",     hb(265, RA), 32'd0);
    chk("ready_hold_f3",   hb(516, RA), 32'd0);
    chk("ready_reopen_f3", hb(517, RA), 32'd1);
    chk("ready_xfer3",     hb(518, RA), 32'd0);
    chk("ready_xfer4",     hb(774, RA), 32'd0);

    // bclk period 8, wclk edges on slot 16 / slot 0 entry.
    chk("bclk_e3",  hb(3, BA),  32'd0);
    chk("bclk_e4",  hb(4, BA),  32'd1);
    chk("bclk_e7",  hb(7, BA),  32'd1);
    chk("bclk_e8",  hb(8, BA),  32'd0);
    chk("bclk_e12", hb(12, BA), 32'd1);
    chk("wclk_e123", hb(123, WA), 32'd0);
    chk("wclk_e124", hb(124, WA), 32'd1);
    chk("wclk_e251", hb(251, WA), 32'd1);
    chk("wclk_e252", hb(252, WA), 32'd0);
    chk("wclk_e380", hb(380, WA), 32'd1);
    chk("wclk_slot20", hb(928, WA), 32'd1);

    // Frame 1 data and underrun behaviour.
    grab(0, 1, 8, DA, word_s);
    chk("f1_left", {16'd0, word_s}, 32'h0000A55A);
    grab(0, 17, 8, DA, word_s);
    chk("f1_right", {16'd0, word_s}, 32'h00000F0F);
    cnt_s = 0;
    for (int i = 1; i < 260; i++) cnt_s += int'(hist[i][UA]);
    chk("f1_no_underrun", cnt_s, 32'd0);
    chk("f2_underrun",      hb(260, UA), 32'd1);
    chk("f2_underrun_once", hb(261, UA), 32'd0);
    chk("f2_slot1_zero",    hb(264, DA), 32'd0);

    // Frame 3 carries the first pair of the held stream, not the change.
    chk("f3_no_underrun", hb(516, UA), 32'd0);
    grab(512, 1, 8, DA, word_s);
    chk("f3_left", {16'd0, word_s}, 32'h00001234);
    grab(512, 17, 8, DA, word_s);
    chk("f3_right", {16'd0, word_s}, 32'h00008001);
    chk("f4_slot1", hb(776, DA), 32'd0);
    chk("f4_slot2", hb(784, DA), 32'd1);

    // After mid-frame reset: empty frame with underrun, held pair gone.
    chk("post_ready",      hb(930, RA), 32'd1);
    chk("post_no_early_u", hb(932, UA), 32'd0);
    chk("post_underrun",   hb(933, UA), 32'd1);
    chk("post_u_once",     hb(934, UA), 32'd0);
    cnt_s = 0;
    for (int s = 1; s <= 32; s++) cnt_s += int'(hist[929 + 8 * s][DA]);
    chk("post_data_zero", cnt_s, 32'd0);

    // BCLK_DIV=2 instance: period 4, second frame carries 8000/0001.
    chk("b_bclk_e2",     hb(2, BB),   32'd1);
    chk("b_bclk_e4",     hb(4, BB),   32'd0);
    chk("b_f1_underrun", hb(2, UB),   32'd1);
    chk("b_ready_xfer",  hb(4, RB),   32'd0);
    chk("b_f2_no_u",     hb(130, UB), 32'd0);
    chk("b_slot0",       hb(128, DB), 32'd0);
    chk("b_slot1",       hb(132, DB), 32'd1);
    chk("b_slot16",      hb(192, DB), 32'd0);
    chk("b_wclk16",      hb(192, WB), 32'd1);
    chk("b_slot17",      hb(196, DB), 32'd0);
    chk("b_slot31",      hb(252, DB), 32'd0);
    chk("b_slot0_next",  hb(256, DB), 32'd1);
    grab(128, 1, 4, DB, word_s);
    chk("b_left", {16'd0, word_s}, 32'h00008000);
    grab(128, 17, 4, DB, word_s);
    chk("b_right", {16'd0, word_s}, 32'h00000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
